// File: rtl/uart_word_serializer.sv
// Pops one word from a first-word-fall-through TX FIFO and feeds it byte by byte to the UART
// transmitter. Define UART_SER_CHECKSUM_EN to append an XOR checksum byte to every word.
module uart_word_serializer #(
    parameter int DATA_BITS = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_fifo_empty,
    input  logic [DATA_BITS-1:0] i_fifo_data,
    output logic                 o_fifo_rd,
    input  logic                 i_uart_done,
    output logic                 o_uart_start,
    output logic [7:0]           o_uart_data,
    output logic                 o_busy
);
    // state     | meaning
    // IDLE      | waiting for the FIFO to hold a word
    // LOAD      | pop the head word, stage its first byte
    // START     | one-cycle start request to the transmitter
    // WAIT_DONE | byte on the line, waiting for the done pulse

    localparam int NBYTES = DATA_BITS / 8;
`ifdef UART_SER_CHECKSUM_EN
    localparam int TOTAL = NBYTES + 1;
    localparam logic [((NBYTES + 1) > 1 ? $clog2(NBYTES + 1) : 1)-1:0] LAST_DATA_IDX =
        ((NBYTES + 1) > 1 ? $clog2(NBYTES + 1) : 1)'(NBYTES - 1);
`else
    localparam int TOTAL = NBYTES;
`endif
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shifted;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_uart_data;
    logic [7:0]           w_first_byte;
    logic [7:0]           w_next_byte;
    logic [7:0]           w_next_tx;
    logic                 w_advance;

    // The byte to send next always sits at the same end of the shift register.
    assign w_shifted    = MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
    assign w_first_byte = MSB_FIRST ? i_fifo_data[DATA_BITS-1 -: 8] : i_fifo_data[7:0];
    assign w_next_byte  = MSB_FIRST ? w_shifted[DATA_BITS-1 -: 8] : w_shifted[7:0];
    assign w_advance    = (r_state == WAIT_DONE) && i_uart_done && (r_idx != LAST_IDX);

`ifdef UART_SER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       w_send_csum;

    assign w_send_csum = (r_idx == LAST_DATA_IDX);
    assign w_next_tx   = w_send_csum ? r_csum : w_next_byte;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_csum <= '0;
        end else if (r_state == LOAD) begin
            r_csum <= w_first_byte;
        end else if (w_advance && !w_send_csum) begin
            r_csum <= r_csum ^ w_next_byte;
        end
    end
`else
    assign w_next_tx = w_next_byte;
`endif

    always_comb begin
        w_next_state = r_state;
        o_fifo_rd    = 1'b0;
        o_uart_start = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (!i_fifo_empty) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                o_fifo_rd    = 1'b1;
                w_next_state = START;
            end
            START: begin
                o_uart_start = 1'b1;
                w_next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_uart_done) begin
                    w_next_state = (r_idx == LAST_IDX) ? IDLE : START;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_uart_data <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == LOAD) begin
                r_shift     <= i_fifo_data;
                r_idx       <= '0;
                r_uart_data <= w_first_byte;
            end else if (w_advance) begin
                r_shift     <= w_shifted;
                r_idx       <= r_idx + 1'b1;
                r_uart_data <= w_next_tx;
            end
        end
    end

    assign o_uart_data = r_uart_data;

endmodule
